// File: rtl/stage1_replay.sv
// Captures Stage 1 samples, derives variance from E[x]/E[x^2] and replays centred samples to Stage 2.
// Optional macro STAGE1_REPLAY_VAR_CLAMP_EN clamps a negative variance to zero.
module stage1_replay #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [8:0]  i_x_norm,
    input  logic        i_S1_done,
    input  logic [21:0] i_Ex,
    input  logic [31:0] i_Ex2,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [22:0] o_xc,
    output logic [31:0] o_var,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [1:0] {FILL, CALC, OUT} state_t;

    localparam logic [CW:0]   FULL     = (CW+1)'(N);
    localparam logic [CW:0]   CNT_ONE  = (CW+1)'(1);
    localparam logic [CW-1:0] PTR_ONE  = CW'(1);

    state_t state, state_nxt;

    logic [8:0]         sample_mem [N];
    logic [CW:0]        wr_cnt;
    logic [CW-1:0]      rd_ptr;
    logic [CW-1:0]      rd_nxt;
    logic signed [21:0] ex_r;
    logic [31:0]        ex2_r;

    logic wr_en, err_set, latch_ex, start_out, advance, finish;

    logic signed [43:0] ex_ext;
    logic signed [43:0] sq;
    logic [32:0]        var_raw;
    logic [31:0]        var_sel;
    logic [8:0]         rd_sample;
    logic [22:0]        xc_nxt;
    logic               last_nxt;
    logic               unused_bits;

    // Q8.14 squared is Q16.28; dropping 12 fraction bits aligns it with E[x^2] in Q16.16.
    assign ex_ext  = {{22{ex_r[21]}}, ex_r};
    assign sq      = ex_ext * ex_ext;
    assign var_raw = {1'b0, ex2_r} - {1'b0, sq[43:12]};

`ifdef STAGE1_REPLAY_VAR_CLAMP_EN
    assign var_sel     = var_raw[32] ? 32'd0 : var_raw[31:0];
    assign unused_bits = ^sq[11:0];
`else
    assign var_sel     = var_raw[31:0];
    assign unused_bits = ^{sq[11:0], var_raw[32]};
`endif

    assign rd_nxt    = start_out ? '0 : rd_ptr + PTR_ONE;
    assign rd_sample = sample_mem[rd_nxt];
    assign xc_nxt    = {{5{rd_sample[8]}}, rd_sample, 14'd0} - {ex_r[21], ex_r};
    assign last_nxt  = ({1'b0, rd_nxt} == (wr_cnt - CNT_ONE));
    assign o_busy    = (state != FILL);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= FILL;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        latch_ex  = 1'b0;
        start_out = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            FILL: begin
                if (i_valid) begin
                    if (wr_cnt < FULL) wr_en   = 1'b1;
                    else               err_set = 1'b1;
                end
                if (i_S1_done) begin
                    latch_ex  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (i_valid || i_S1_done) err_set = 1'b1;
                if (wr_cnt == '0) begin
                    err_set   = 1'b1;
                    state_nxt = FILL;
                end else begin
                    start_out = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (i_valid || i_S1_done) err_set = 1'b1;
                if (o_valid && i_ready) begin
                    if (o_last) begin
                        finish    = 1'b1;
                        state_nxt = FILL;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // NOTE: the sample buffer is deliberately left out of reset; wr_cnt alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (wr_en) sample_mem[wr_cnt[CW-1:0]] <= i_x_norm;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            ex_r    <= '0;
            ex2_r   <= '0;
            o_valid <= 1'b0;
            o_xc    <= '0;
            o_var   <= '0;
            o_last  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (wr_en)    wr_cnt <= wr_cnt + CNT_ONE;
            if (latch_ex) begin
                ex_r  <= i_Ex;
                ex2_r <= i_Ex2;
            end
            if (err_set)       o_err <= 1'b1;
            if (state == CALC) o_var <= var_sel;
            if (start_out || advance) begin
                rd_ptr  <= rd_nxt;
                o_xc    <= xc_nxt;
                o_last  <= last_nxt;
                o_valid <= 1'b1;
            end
            if (finish) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
                wr_cnt  <= '0;
                rd_ptr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stage1_replay.sv
// Directed, table-driven bench for stage1_replay: token vectors with hand-computed expectations
// plus hand-written reset, clamp and empty-token sequences.
module tb_stage1_replay;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_S1_done, i_ready;
    logic [8:0]  i_x_norm;
    logic [21:0] i_Ex;
    logic [31:0] i_Ex2;
    logic        o_valid, o_last, o_busy, o_err;
    logic [22:0] o_xc;
    logic [31:0] o_var;

    int checks = 0;
    int errors = 0;

    stage1_replay #(.N(8), .CW(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_x_norm(i_x_norm),
        .i_S1_done(i_S1_done), .i_Ex(i_Ex), .i_Ex2(i_Ex2), .i_ready(i_ready),
        .o_valid(o_valid), .o_xc(o_xc), .o_var(o_var), .o_last(o_last),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          n;
        int          x [9];
        logic [21:0] ex;
        logic [31:0] ex2;
        logic [31:0] var_e;
        int          xc [8];
    } vec_t;

    typedef struct {
        int   vi;
        int   mode;     // 0: ready held high, 1: ready pattern 1,0,0,1
        logic err_e;
        int   abort_k;  // beat index at which reset is asserted, -1 for none
    } run_t;

    vec_t vecs [5];
    run_t runs [9];

`ifdef STAGE1_REPLAY_VAR_CLAMP_EN
    localparam logic [31:0] CLAMP_VAR = 32'd0;
`else
    localparam logic [31:0] CLAMP_VAR = 32'hFFFF0000;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_rst = 1'b1;
        tick;
        tick;
        i_rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_xc"},    o_xc,    0);
        check({tag, "_var"},   o_var,   0);
        check({tag, "_last"},  o_last,  0);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_err"},   o_err,   0);
    endtask

    task automatic load(input vec_t v, input bit merge_done);
        for (int i = 0; i < v.n; i++) begin
            i_valid  = 1'b1;
            i_x_norm = 9'(v.x[i]);
            if (merge_done && i == v.n - 1) begin
                i_S1_done = 1'b1;
                i_Ex      = v.ex;
                i_Ex2     = v.ex2;
            end
            tick;
        end
        i_valid = 1'b0;
        if (!merge_done) begin
            i_S1_done = 1'b1;
            i_Ex      = v.ex;
            i_Ex2     = v.ex2;
            tick;
        end
        i_S1_done = 1'b0;
    endtask

    task automatic replay(input vec_t v, input int mode, input logic err_e, input int abort_k);
        int cnt, k, cyc;
        logic [22:0] exc;
        cnt = (v.n > 8) ? 8 : v.n;
        check("calc_valid", o_valid, 0);
        check("calc_busy",  o_busy,  1);
        tick;
        k   = 0;
        cyc = 0;
        while (k < cnt && cyc < 64) begin
            if (k == abort_k) begin
                i_rst = 1'b1;
                tick;
                i_rst   = 1'b0;
                i_ready = 1'b0;
                check_idle("abort");
                return;
            end
            i_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            exc = v.xc[k];
            check("beat_valid", o_valid, 1);
            check("beat_xc",    o_xc,    exc);
            check("beat_var",   o_var,   v.var_e);
            check("beat_last",  o_last,  (k == cnt - 1));
            check("beat_err",   o_err,   err_e);
            check("beat_busy",  o_busy,  1);
            if (i_ready) k++;
            cyc++;
            tick;
        end
        i_ready = 1'b0;
        check("replay_count", k, cnt);
        check("end_valid", o_valid, 0);
        check("end_busy",  o_busy,  0);
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_S1_done = 1'b0; i_ready = 1'b0;
        i_x_norm = '0; i_Ex = '0; i_Ex2 = '0;

        vecs[0] = '{8, '{5, 5, 5, 5, 5, 5, 5, 5, 0}, 22'd81920, 32'd1638400, 32'd0,
                    '{0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[1] = '{8, '{10, -10, 10, -10, 10, -10, 10, -10, 0}, 22'd0, 32'd6553600, 32'd6553600,
                    '{163840, -163840, 163840, -163840, 163840, -163840, 163840, -163840}};
        vecs[2] = '{3, '{-128, 0, 127, 0, 0, 0, 0, 0, 0}, 22'h3FC000, 32'd710000, 32'd644464,
                    '{-2080768, 16384, 2097152, 0, 0, 0, 0, 0}};
        vecs[3] = '{9, '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 22'd73728, 32'd1671168, 32'd344064,
                    '{-57344, -40960, -24576, -8192, 8192, 24576, 40960, 57344}};
        vecs[4] = '{1, '{1, 0, 0, 0, 0, 0, 0, 0, 0}, 22'd16384, 32'd0, CLAMP_VAR,
                    '{0, 0, 0, 0, 0, 0, 0, 0}};

        runs[0] = '{0, 0, 1'b0, -1};
        runs[1] = '{1, 0, 1'b0, -1};
        runs[2] = '{1, 1, 1'b0, -1};
        runs[3] = '{2, 0, 1'b0, -1};
        runs[4] = '{3, 0, 1'b1, -1};
        runs[5] = '{0, 0, 1'b1, -1};
        runs[6] = '{0, 0, 1'b1, 3};
        runs[7] = '{1, 0, 1'b0, -1};
        runs[8] = '{4, 0, 1'b0, -1};

        do_reset;
        check_idle("reset");

        // Vector 2 presents its last sample together with the done pulse.
        foreach (runs[r]) begin
            load(vecs[runs[r].vi], runs[r].vi == 2);
            replay(vecs[runs[r].vi], runs[r].mode, runs[r].err_e, runs[r].abort_k);
        end

        // Done with an empty buffer: one CALC cycle, back to FILL with no output and an error.
        do_reset;
        i_S1_done = 1'b1; i_Ex = 22'd0; i_Ex2 = 32'd0;
        tick;
        i_S1_done = 1'b0;
        check("empty_calc_busy", o_busy, 1);
        tick;
        check("empty_valid", o_valid, 0);
        check("empty_busy",  o_busy,  0);
        check("empty_err",   o_err,   1);
        tick;
        check("empty_valid2", o_valid, 0);

        // A strobe arriving during replay is dropped and flags an error.
        do_reset;
        load(vecs[1], 1'b0);
        i_valid = 1'b1; i_x_norm = 9'd3;
        tick;
        i_valid = 1'b0;
        check("calc_strobe_err", o_err, 1);
        tick;
        check("strobe_first_xc", o_xc, 23'd163840);
        check("strobe_valid",    o_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
